// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encodings and port indices.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant chooser for simultaneous requests seen in IDLE.
// Build option: RAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-0 priority.
module ram_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic valid,
    output logic pick
);

    assign valid = req0 | req1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // On a tie, favour the port that did not win the previous IDLE pick.
    assign pick = (req0 && req1) ? ~last_gnt : ~req0;
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
    assign pick = ~req0;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM: IDLE -> ACCESS -> RESP.
// Build option: RAM_ARB_ROUND_ROBIN_EN (handled inside ram_arb_pick).
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DSIZE = 16,
    parameter int ASIZE = 14
) (
    input  logic             clk,
    input  logic             reset_b,
    // Handshake: a master raises mX_req with rnw/addr/wdata stable and holds it
    // until the one-cycle mX_ack; rdata is meaningful only while ack is high.
    input  logic             m0_req,
    input  logic             m0_rnw,
    input  logic [ASIZE-1:0] m0_addr,
    input  logic [DSIZE-1:0] m0_wdata,
    output logic             m0_ack,
    output logic [DSIZE-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_rnw,
    input  logic [ASIZE-1:0] m1_addr,
    input  logic [DSIZE-1:0] m1_wdata,
    output logic             m1_ack,
    output logic [DSIZE-1:0] m1_rdata,
    output logic             ram_cs_b,
    output logic             ram_rnw,
    output logic [ASIZE-1:0] ram_addr,
    output logic [DSIZE-1:0] ram_din,
    input  logic [DSIZE-1:0] ram_dout,
    output logic [1:0]       dbg_state_o
);

    arb_state_e       state_q;
    logic             gnt_q;
    logic             last_gnt_q;
    logic             ram_cs_b_q;
    logic             ram_rnw_q;
    logic [ASIZE-1:0] ram_addr_q;
    logic [DSIZE-1:0] ram_din_q;

    logic             pick_valid;
    logic             pick_port;
    logic             load_port;
    logic             other_req;
    logic             sel_rnw;
    logic [ASIZE-1:0] sel_addr;
    logic [DSIZE-1:0] sel_wdata;

    ram_arb_pick u_pick (
        .req0     (m0_req),
        .req1     (m1_req),
        .last_gnt (last_gnt_q),
        .valid    (pick_valid),
        .pick     (pick_port)
    );

    // In RESP the granted port still shows its finished request, so only the other port may follow.
    assign other_req = (gnt_q == ARB_M0) ? m1_req : m0_req;
    assign load_port = (state_q == ARB_RESP) ? ~gnt_q : pick_port;
    assign sel_rnw   = (load_port == ARB_M1) ? m1_rnw   : m0_rnw;
    assign sel_addr  = (load_port == ARB_M1) ? m1_addr  : m0_addr;
    assign sel_wdata = (load_port == ARB_M1) ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= ARB_M0;
            last_gnt_q <= ARB_M1;
            ram_cs_b_q <= 1'b1;
            ram_rnw_q  <= 1'b1;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state_q    <= ARB_ACCESS;
                        gnt_q      <= pick_port;
                        // Only the IDLE pick is remembered; hand-over already alternates.
                        last_gnt_q <= pick_port;
                        ram_cs_b_q <= 1'b0;
                        ram_rnw_q  <= sel_rnw;
                        ram_addr_q <= sel_addr;
                        ram_din_q  <= sel_wdata;
                    end
                end
                ARB_ACCESS: begin
                    state_q    <= ARB_RESP;
                    ram_cs_b_q <= 1'b1;
                end
                ARB_RESP: begin
                    if (other_req) begin
                        state_q    <= ARB_ACCESS;
                        gnt_q      <= ~gnt_q;
                        ram_cs_b_q <= 1'b0;
                        ram_rnw_q  <= sel_rnw;
                        ram_addr_q <= sel_addr;
                        ram_din_q  <= sel_wdata;
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q    <= ARB_IDLE;
                    ram_cs_b_q <= 1'b1;
                end
            endcase
        end
    end

    assign ram_cs_b    = ram_cs_b_q;
    assign ram_rnw     = ram_rnw_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign dbg_state_o = state_q;

    assign m0_ack   = (state_q == ARB_RESP) && (gnt_q == ARB_M0);
    assign m1_ack   = (state_q == ARB_RESP) && (gnt_q == ARB_M1);
    assign m0_rdata = m0_ack ? ram_dout : '0;
    assign m1_rdata = m1_ack ? ram_dout : '0;

endmodule
